// File: rtl/register_restore_pkg.sv
// Shared types and constants for the register-file rollback engine.
package restore_pkg;

    // Default architectural register width used by the core.
    localparam int DATA_WIDTH_DEF = 32;

    // Register-file address width (32 architectural registers).
    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        R_IDLE,
        R_DRAIN,
        R_RESTORE,
        R_FINISH
    } restore_state_t;

endpackage

// File: rtl/register_restore_if.sv
// Bundle between hazard control, the rollback engine and the register-file write ports.
interface register_restore_if #(
    parameter int DATA_WIDTH      = 32,
    parameter int NUM_REGS        = 32,
    parameter int PORTS_PER_CYCLE = 4
);

    // Request side (hazard control / snapshot capture)
    logic                                              restore_req;
    logic                                              snapshot_valid;
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0]               regs_snapshot;

    // Register-file write ports and status back to hazard control
    logic [PORTS_PER_CYCLE-1:0]                        rf_we;
    logic [PORTS_PER_CYCLE-1:0][restore_pkg::REG_ADDR_W-1:0] rf_waddr;
    logic [PORTS_PER_CYCLE-1:0][DATA_WIDTH-1:0]        rf_wdata;
    logic                                              stall;
    logic                                              done;
    logic                                              err;

    modport master (
        output restore_req, snapshot_valid, regs_snapshot,
        input  rf_we, rf_waddr, rf_wdata, stall, done, err
    );

    modport slave (
        input  restore_req, snapshot_valid, regs_snapshot,
        output rf_we, rf_waddr, rf_wdata, stall, done, err
    );

endinterface

// File: rtl/register_restore.sv
// Rollback engine: after a misprediction, drains one cycle, freezes a copy of the
// register snapshot and streams it into the register file PORTS_PER_CYCLE registers
// per cycle while stalling the pipeline. Requests arriving mid-restore queue one re-run.
module register_restore
    import restore_pkg::*;
#(
    parameter int DATA_WIDTH      = DATA_WIDTH_DEF,
    parameter int NUM_REGS        = 32,
    parameter int PORTS_PER_CYCLE = 4
) (
    input  logic               clk,
    input  logic               rst,
    register_restore_if.slave  bus
);

    localparam int IDX_W = $clog2(NUM_REGS) + 1;   // one spare bit so idx never wraps
    localparam int SEL_W = $clog2(NUM_REGS);
    localparam int P     = PORTS_PER_CYCLE;

    if ((NUM_REGS % PORTS_PER_CYCLE) != 0) begin : g_param_check
        $error("register_restore: NUM_REGS must be a multiple of PORTS_PER_CYCLE");
    end

    restore_state_t                 state_q, state_d;
    logic [IDX_W-1:0]               idx_q, idx_d;
    logic                           pending_q, pending_d;
    logic [DATA_WIDTH-1:0]          copy_q [NUM_REGS];
    logic                           stall_q, stall_d;
    logic                           done_q, done_d;
    logic                           err_q, err_d;
    logic [P-1:0]                   rf_we_q, rf_we_d;
    logic [P-1:0][REG_ADDR_W-1:0]   rf_waddr_q, rf_waddr_d;
    logic [P-1:0][DATA_WIDTH-1:0]   rf_wdata_q, rf_wdata_d;

    logic [IDX_W-1:0]               idx_step;
    logic                           last_batch;
    logic                           load_rf;
    logic [IDX_W-1:0]               base;

    // Write ports are registered, so each cycle prepares the batch shown next cycle:
    // DRAIN prepares batch 0 straight from the snapshot (being latched this same edge),
    // RESTORE prepares the following batch from the frozen copy.
    assign idx_step   = idx_q + IDX_W'(P);
    assign last_batch = (idx_step >= IDX_W'(NUM_REGS));
    assign load_rf    = (state_q == R_DRAIN) || ((state_q == R_RESTORE) && !last_batch);
    assign base       = (state_q == R_DRAIN) ? '0 : idx_step;

    for (genvar gi = 0; gi < P; gi++) begin : g_port
        logic [SEL_W-1:0]      sel;
        logic [REG_ADDR_W-1:0] addr;

        // Address is 5-bit wrap-free by construction: idx[4:0]+p never carries past 31.
        assign sel              = SEL_W'(base) + SEL_W'(gi);
        assign addr             = REG_ADDR_W'(base) + REG_ADDR_W'(gi);
        assign rf_we_d[gi]      = load_rf && (addr != '0);   // r0 is hard-wired, never written
        assign rf_waddr_d[gi]   = load_rf ? addr : '0;
        assign rf_wdata_d[gi]   = !load_rf                ? '0 :
                                  (state_q == R_DRAIN)    ? bus.regs_snapshot[sel] :
                                                            copy_q[sel];
    end

    // Next-state logic for the rollback sequence and the one-deep request queue
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pending_d = pending_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            R_IDLE: begin
                if (bus.restore_req) begin
                    if (bus.snapshot_valid) state_d = R_DRAIN;
                    else                    err_d   = 1'b1;
                end
            end
            R_DRAIN: begin
                if (bus.restore_req) pending_d = 1'b1;
                state_d = R_RESTORE;
                idx_d   = '0;
            end
            R_RESTORE: begin
                if (bus.restore_req) pending_d = 1'b1;
                if (last_batch) begin
                    state_d = R_FINISH;
                    done_d  = 1'b1;
                end else begin
                    idx_d = idx_step;
                end
            end
            R_FINISH: begin
                // A request landing in FINISH itself is folded into the queued re-run.
                if (pending_q || bus.restore_req) begin
                    pending_d = 1'b0;
                    if (bus.snapshot_valid) begin
                        state_d = R_DRAIN;
                    end else begin
                        state_d = R_IDLE;
                        err_d   = 1'b1;
                    end
                end else begin
                    state_d = R_IDLE;
                end
            end
            default: state_d = R_IDLE;
        endcase
        stall_d = (state_d == R_DRAIN) || (state_d == R_RESTORE);
    end

    // State, frozen snapshot copy and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= R_IDLE;
            idx_q      <= '0;
            pending_q  <= 1'b0;
            stall_q    <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rf_we_q    <= '0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) copy_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            pending_q  <= pending_d;
            stall_q    <= stall_d;
            done_q     <= done_d;
            err_q      <= err_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            if (state_q == R_DRAIN) begin
                for (int i = 0; i < NUM_REGS; i++) copy_q[i] <= bus.regs_snapshot[i];
            end
        end
    end

    assign bus.rf_we    = rf_we_q;
    assign bus.rf_waddr = rf_waddr_q;
    assign bus.rf_wdata = rf_wdata_q;
    assign bus.stall    = stall_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;

endmodule
